// File: rtl/control_out_pkg_hdl.sv
// Shared types, default parameters and helpers for the control_out capture path.
package control_out_pkg_hdl;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_CTRL_W = 16;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_TS_W   = 16;
    localparam int unsigned DEF_CNT_W  = 8;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    localparam int unsigned DEF_CH_W = ch_idx_w(DEF_NUM_CH);

    // Per-channel holding register occupancy.
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    // FIFO entry as seen by the HVL proxy at default widths.
    typedef struct packed {
        logic [DEF_CTRL_W-1:0] data;
        logic [DEF_CH_W-1:0]   ch;
        logic [DEF_TS_W-1:0]   ts;
    } co_entry_t;

endpackage

// File: rtl/control_out_rr_arb.sv
// Round-robin arbiter over full holding registers, starting the search at rr_ptr.
module control_out_rr_arb
    import control_out_pkg_hdl::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH
) (
    input  logic [NUM_CH-1:0]                 req,
    input  logic [ch_idx_w(NUM_CH)-1:0]       rr_ptr,
    input  logic                              enable,
    output logic [NUM_CH-1:0]                 grant_c,
    output logic [ch_idx_w(NUM_CH)-1:0]       grant_idx_c,
    output logic                              grant_valid_c
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    // First requester at or after rr_ptr (wrapping) wins, only when a push is possible.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx           = '0;
        grant_c       = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((32'(rr_ptr) + k) % NUM_CH);
            if (enable && !grant_valid_c && req[idx]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = idx;
                grant_c[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_out_capture.sv
// Multi-channel control_out capture: per-channel hold regs, round-robin into a timestamped FIFO.
module control_out_capture
    import control_out_pkg_hdl::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned TS_W   = DEF_TS_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             ch_valid,
    input  logic [NUM_CH*CTRL_W-1:0]      ch_data,
    input  logic                          change_mode,
    input  logic                          clr_stats,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CTRL_W-1:0]             out_data,
    output logic [ch_idx_w(NUM_CH)-1:0]   out_ch,
    output logic [TS_W-1:0]               out_ts,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [NUM_CH-1:0]             drop_flag
);

    localparam int unsigned CH_W   = ch_idx_w(NUM_CH);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 5;

    logic [TS_W-1:0]                 ts_q;
    hold_state_e                     hold_state_q [NUM_CH];
    hold_state_e                     hold_state_d [NUM_CH];
    logic [NUM_CH-1:0][CTRL_W-1:0]   hold_data_q;
    logic [NUM_CH-1:0][TS_W-1:0]     hold_ts_q;
    logic [NUM_CH-1:0][CTRL_W-1:0]   last_q;
    logic [NUM_CH-1:0]               seen_q;
    logic [CH_W-1:0]                 rr_ptr_q;

    logic [CTRL_W-1:0]               mem_data [DEPTH];
    logic [CH_W-1:0]                 mem_ch   [DEPTH];
    logic [TS_W-1:0]                 mem_ts   [DEPTH];
    logic [PTR_W-1:0]                wr_ptr_q;
    logic [PTR_W-1:0]                rd_ptr_q;

    logic [NUM_CH-1:0]               qual_c;
    logic [NUM_CH-1:0]               req_c;
    logic [NUM_CH-1:0]               drop_c;
    logic [NUM_CH-1:0]               grant_c;
    logic [CH_W-1:0]                 grant_idx_c;
    logic                            grant_valid_c;
    logic                            pop_c;
    logic                            push_ok_c;
    logic [FCNT_W-1:0]               count_d;
    logic [SUM_W-1:0]                drop_sum_c;
    logic [CNT_W-1:0]                drop_cnt_d;
    logic [NUM_CH-1:0]               drop_flag_d;

    assign pop_c     = out_valid & out_ready;
    assign push_ok_c = (fifo_count < FCNT_W'(DEPTH)) | pop_c;

    // Head is read straight from FIFO storage flops; no path from ch_* inputs.
    assign out_data = mem_data[rd_ptr_q];
    assign out_ch   = mem_ch[rd_ptr_q];
    assign out_ts   = mem_ts[rd_ptr_q];

    // Sample qualification: every strobe, or only strobes carrying a new value.
    always_comb begin
        qual_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (change_mode) begin
                qual_c[i] = ch_valid[i] &&
                            (!seen_q[i] || (ch_data[i*CTRL_W +: CTRL_W] != last_q[i]));
            end else begin
                qual_c[i] = ch_valid[i];
            end
        end
    end

    // Hold reg next state; an ungranted full reg hit by a new sample is a drop.
    always_comb begin
        drop_c = '0;
        req_c  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            hold_state_d[i] = hold_state_q[i];
            req_c[i]        = (hold_state_q[i] == HOLD_FULL);
            case (hold_state_q[i])
                HOLD_EMPTY: begin
                    if (qual_c[i]) hold_state_d[i] = HOLD_FULL;
                end
                HOLD_FULL: begin
                    if (qual_c[i]) begin
                        hold_state_d[i] = HOLD_FULL;
                        drop_c[i]       = !grant_c[i];
                    end else if (grant_c[i]) begin
                        hold_state_d[i] = HOLD_EMPTY;
                    end
                end
                default: hold_state_d[i] = HOLD_EMPTY;
            endcase
        end
    end

    control_out_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req           (req_c),
        .rr_ptr        (rr_ptr_q),
        .enable        (push_ok_c),
        .grant_c       (grant_c),
        .grant_idx_c   (grant_idx_c),
        .grant_valid_c (grant_valid_c)
    );

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_d = fifo_count;
        case ({grant_valid_c, pop_c})
            2'b10:   count_d = fifo_count + FCNT_W'(1);
            2'b01:   count_d = fifo_count - FCNT_W'(1);
            default: count_d = fifo_count;
        endcase
    end

    // Saturating drop accumulation; clr_stats wins over a same-cycle drop.
    always_comb begin
        drop_sum_c = SUM_W'(drop_cnt);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drop_sum_c = drop_sum_c + SUM_W'(drop_c[i]);
        end
        if (clr_stats) begin
            drop_cnt_d  = '0;
            drop_flag_d = '0;
        end else begin
            drop_cnt_d  = (drop_sum_c > SUM_W'({CNT_W{1'b1}})) ? '1 : drop_sum_c[CNT_W-1:0];
            drop_flag_d = drop_flag | drop_c;
        end
    end

    // Timestamp, hold regs, change-detect history and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q        <= '0;
            hold_data_q <= '0;
            hold_ts_q   <= '0;
            last_q      <= '0;
            seen_q      <= '0;
            rr_ptr_q    <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                hold_state_q[i] <= HOLD_EMPTY;
            end
        end else begin
            ts_q <= ts_q + TS_W'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                hold_state_q[i] <= hold_state_d[i];
                if (qual_c[i]) begin
                    hold_data_q[i] <= ch_data[i*CTRL_W +: CTRL_W];
                    hold_ts_q[i]   <= ts_q;
                    last_q[i]      <= ch_data[i*CTRL_W +: CTRL_W];
                    seen_q[i]      <= 1'b1;
                end
            end
            if (grant_valid_c) begin
                rr_ptr_q <= (grant_idx_c == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_c + CH_W'(1);
            end
        end
    end

    // FIFO storage, pointers and registered occupancy/valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
            out_valid  <= 1'b0;
            for (int unsigned d = 0; d < DEPTH; d++) begin
                mem_data[d] <= '0;
                mem_ch[d]   <= '0;
                mem_ts[d]   <= '0;
            end
        end else begin
            if (grant_valid_c) begin
                mem_data[wr_ptr_q] <= hold_data_q[grant_idx_c];
                mem_ch[wr_ptr_q]   <= grant_idx_c;
                mem_ts[wr_ptr_q]   <= hold_ts_q[grant_idx_c];
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_count <= count_d;
            out_valid  <= (count_d != '0);
        end
    end

    // Drop statistics registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt  <= '0;
            drop_flag <= '0;
        end else begin
            drop_cnt  <= drop_cnt_d;
            drop_flag <= drop_flag_d;
        end
    end

endmodule
